// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit
//   Instruction fetch and PC sequencing for a simple multi-cycle CPU.
//   The FSM moves IDLE -> FETCH -> EXEC -> FETCH ... until HALT. FETCH holds a
//   request to memory. EXEC waits for the execute FSM to report completion and
//   then applies halt, register branch, conditional PC-relative branch and link.
//
// Ports
//   CLOCK_50, rst_n          clock (rising edge), asynchronous active-low reset
//   start                    level; leaves IDLE
//   mem_req/mem_addr         fetch request and address (address is the PC)
//   mem_rdy/mem_rdata        memory acknowledge and instruction word
//   exec_done                completion pulse; qualifies halt/br_en/br_reg/link_en
//   cond, status, sximm8     branch condition, Z/N/V flags, sign-extended offset
//   reg_target               register branch target
//   ir, ir_valid             instruction register and its one-cycle load strobe
//   link_pc                  saved return address
//   running, halted          FETCH/EXEC indicator, HALT indicator
//   dbg_state                current FSM state, for observation only
//
// Handshake: mem_req is high for the whole time the FSM sits in FETCH and
// mem_addr is held constant while it is high. The transfer completes on the
// rising edge where mem_req and mem_rdy are both 1; mem_rdy while mem_req is 0
// has no effect. Any number of wait states is allowed.
module fetch_branch_unit #(
  parameter int PC_W     = 8,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              exec_done,
  input  logic              halt,
  input  logic              br_en,
  input  logic              br_reg,
  input  logic              link_en,
  input  logic [2:0]        cond,
  input  logic [2:0]        status,
  input  logic [PC_W-1:0]   sximm8,
  input  logic [PC_W-1:0]   reg_target,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [PC_W-1:0]   link_pc,
  output logic              running,
  output logic              halted,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc;
  logic            cond_true;
  logic            fetch_ack;
  logic            exec_fire;

  // Condition decode from the Z/N/V flags; codes 101-111 are never taken.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = status[0];
      3'b010:  cond_true = ~status[0];
      3'b011:  cond_true = status[1] ^ status[2];
      3'b100:  cond_true = (status[1] ^ status[2]) | status[0];
      default: cond_true = 1'b0;
    endcase
  end

  assign fetch_ack = (state == S_FETCH) && mem_rdy;
  assign exec_fire = (state == S_EXEC) && exec_done;

  // State register
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; HALT is left only through reset.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)     state_nxt = S_FETCH;
      S_FETCH: if (mem_rdy)   state_nxt = S_EXEC;
      S_EXEC:  if (exec_done) state_nxt = halt ? S_HALT : S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so reset clears them
  // immediately without waiting for a clock edge.
  always_comb begin
    mem_req   = 1'b0;
    running   = 1'b0;
    halted    = 1'b0;
    dbg_state = state;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        running = 1'b1;
      end
      S_EXEC:  running = 1'b1;
      S_HALT:  halted  = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr = pc;

  // Datapath. The PC is incremented when the fetch completes, so during EXEC
  // it already holds the return address and is the base for relative branches.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC_V;
      ir       <= '0;
      ir_valid <= 1'b0;
      link_pc  <= '0;
    end else begin
      ir_valid <= fetch_ack;
      if (fetch_ack) begin
        ir <= mem_rdata;
        pc <= pc + PC_W'(1);
      end
      if (exec_fire && !halt) begin
        if (link_en) link_pc <= pc;
        if (br_reg)                pc <= reg_target;
        else if (br_en && cond_true) pc <= pc + sximm8;
      end
    end
  end

endmodule

// File: tb/tb_fetch_branch_unit.sv
`timescale 1ns/1ps
module tb_fetch_branch_unit;

  // ---------------- clock / reset ----------------
  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;
  logic rst_n = 1'b0;

  // ---------------- shared stimulus ----------------
  logic        start, mem_rdy, exec_done, halt, br_en, br_reg, link_en;
  logic [15:0] mem_rdata;
  logic [2:0]  cond, status;
  logic [7:0]  sximm8, reg_target;
  logic [11:0] sximm8_12, reg_target_12;

  // ---------------- 8-bit instance ----------------
  logic        mem_req, ir_valid, running, halted;
  logic [7:0]  mem_addr, link_pc;
  logic [15:0] ir;
  logic [1:0]  dbg_state;

  fetch_branch_unit #(.PC_W(8), .DATA_W(16), .RESET_PC(0)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .start(start), .mem_rdy(mem_rdy),
    .mem_rdata(mem_rdata), .exec_done(exec_done), .halt(halt), .br_en(br_en),
    .br_reg(br_reg), .link_en(link_en), .cond(cond), .status(status),
    .sximm8(sximm8), .reg_target(reg_target), .mem_req(mem_req),
    .mem_addr(mem_addr), .ir(ir), .ir_valid(ir_valid), .link_pc(link_pc),
    .running(running), .halted(halted), .dbg_state(dbg_state)
  );

  // ---------------- 12-bit instance, non-zero reset PC ----------------
  logic        mem_req_12, ir_valid_12, running_12, halted_12;
  logic [11:0] mem_addr_12, link_pc_12;
  logic [15:0] ir_12;
  logic [1:0]  dbg_state_12;

  fetch_branch_unit #(.PC_W(12), .DATA_W(16), .RESET_PC(12'h100)) dut12 (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .start(start), .mem_rdy(mem_rdy),
    .mem_rdata(mem_rdata), .exec_done(exec_done), .halt(halt), .br_en(br_en),
    .br_reg(br_reg), .link_en(link_en), .cond(cond), .status(status),
    .sximm8(sximm8_12), .reg_target(reg_target_12), .mem_req(mem_req_12),
    .mem_addr(mem_addr_12), .ir(ir_12), .ir_valid(ir_valid_12), .link_pc(link_pc_12),
    .running(running_12), .halted(halted_12), .dbg_state(dbg_state_12)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Reference condition table, straight from the flag definitions.
  function automatic bit cond_model(input logic [2:0] c, input logic [2:0] st);
    bit z, n, v, less;
    z = st[0]; n = st[1]; v = st[2];
    less = (n != v);
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return less;
      3'd4: return less || z;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change just after the falling edge, outputs are observed there too.
  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic clear_inputs();
    start = 0; mem_rdy = 0; mem_rdata = '0; exec_done = 0; halt = 0;
    br_en = 0; br_reg = 0; link_en = 0; cond = '0; status = '0;
    sximm8 = '0; reg_target = '0; sximm8_12 = '0; reg_target_12 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  // From FETCH: 'waits' wait states, then the acknowledge. Ends in EXEC.
  task automatic do_fetch(input logic [15:0] data, input int waits);
    for (int i = 0; i < waits; i++) begin
      mem_rdy = 0; mem_rdata = 16'($urandom); tick();
    end
    mem_rdy = 1; mem_rdata = data; tick();
    mem_rdy = 0;
  endtask

  // From EXEC: 'delay' cycles of random (unqualified) controls, then the pulse.
  task automatic do_exec(input logic h, input logic be, input logic brr, input logic le,
                         input logic [2:0] c, input logic [2:0] st,
                         input logic [7:0] off, input logic [7:0] tgt, input int delay);
    for (int i = 0; i < delay; i++) begin
      exec_done = 0; halt = 1'($urandom); br_en = 1'($urandom); br_reg = 1'($urandom);
      link_en = 1'($urandom); cond = 3'($urandom); status = 3'($urandom);
      sximm8 = 8'($urandom); reg_target = 8'($urandom);
      tick();
    end
    exec_done = 1; halt = h; br_en = be; br_reg = brr; link_en = le;
    cond = c; status = st; sximm8 = off; reg_target = tgt;
    sximm8_12 = {{4{off[7]}}, off}; reg_target_12 = {4'h0, tgt};
    tick();
    exec_done = 0; halt = 0; br_en = 0; br_reg = 0; link_en = 0;
  endtask

  // From FETCH: run one plain instruction that register-branches to 'target'.
  task automatic goto_pc(input logic [7:0] target);
    do_fetch(16'h0000, 0);
    do_exec(0, 0, 1, 0, 3'd0, 3'd0, 8'h00, target, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", mem_addr); end
    checks++; if (mem_addr_12 !== 12'h100) begin errors++; $display("FAIL reset_pc_12: got %h expected 100", mem_addr_12); end
    checks++; if (ir !== 16'h0000 || ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir: got ir=%h v=%b expected 0000/0", ir, ir_valid); end
    checks++; if (link_pc !== 8'h00) begin errors++; $display("FAIL reset_link: got %h expected 00", link_pc); end
    checks++; if (running !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_status: got run=%b halt=%b expected 0/0", running, halted); end
    // No start: stays idle.
    mem_rdy = 1; tick(); tick(); mem_rdy = 0;
    checks++; if (running !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL idle_hold: got run=%b req=%b expected 0/0", running, mem_req); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    mem_rdy = 1; mem_rdata = 16'hA5A5;
    start = 1; tick(); start = 0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || ir_valid !== 1'b0) begin errors++;
      $display("FAIL first_fetch_req: got req=%b addr=%h v=%b expected 1/00/0", mem_req, mem_addr, ir_valid); end
    tick();
    checks++; if (ir !== 16'hA5A5 || ir_valid !== 1'b1) begin errors++; $display("FAIL first_fetch_ir: got ir=%h v=%b expected a5a5/1", ir, ir_valid); end
    checks++; if (mem_addr !== 8'h01 || mem_req !== 1'b0 || running !== 1'b1) begin errors++;
      $display("FAIL first_fetch_pc: got addr=%h req=%b run=%b expected 01/0/1", mem_addr, mem_req, running); end
    tick();
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL ir_valid_pulse: got %b expected 0", ir_valid); end
    // start and mem_rdy are ignored while waiting in EXEC.
    start = 1; tick(); tick(); start = 0; mem_rdy = 0;
    checks++; if (running !== 1'b1 || mem_req !== 1'b0 || ir !== 16'hA5A5 || mem_addr !== 8'h01) begin errors++;
      $display("FAIL exec_hold: got run=%b req=%b ir=%h addr=%h expected 1/0/a5a5/01", running, mem_req, ir, mem_addr); end
  endtask

  task automatic test_wait_states();
    do_exec(0, 0, 0, 0, 3'd0, 3'd0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      mem_rdy = 0; mem_rdata = 16'($urandom); start = 1; tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h01 || ir !== 16'hA5A5 || ir_valid !== 1'b0) begin errors++;
        $display("FAIL wait_state_%0d: got req=%b addr=%h ir=%h v=%b expected 1/01/a5a5/0", i, mem_req, mem_addr, ir, ir_valid); end
    end
    start = 0;
    do_fetch(16'h1234, 0);
    checks++; if (ir !== 16'h1234 || mem_addr !== 8'h02 || ir_valid !== 1'b1) begin errors++;
      $display("FAIL wait_state_done: got ir=%h addr=%h v=%b expected 1234/02/1", ir, mem_addr, ir_valid); end
  endtask

  task automatic test_wrap();
    do_reset(); do_start();
    do_fetch(16'h0001, 0);
    exec_done = 1; br_reg = 1; reg_target = 8'hFF; reg_target_12 = 12'hFFF;
    tick();
    exec_done = 0; br_reg = 0;
    checks++; if (mem_addr !== 8'hFF || mem_addr_12 !== 12'hFFF) begin errors++;
      $display("FAIL wrap_setup: got %h/%h expected ff/fff", mem_addr, mem_addr_12); end
    do_fetch(16'h0F0F, 1);
    checks++; if (mem_addr !== 8'h00 || mem_addr_12 !== 12'h000) begin errors++;
      $display("FAIL pc_wrap: got %h/%h expected 00/000", mem_addr, mem_addr_12); end
    do_exec(0, 1, 0, 0, 3'b000, 3'b000, 8'hFE, 8'h00, 0);
    checks++; if (mem_addr !== 8'hFE || mem_addr_12 !== 12'hFFE) begin errors++;
      $display("FAIL neg_branch: got %h/%h expected fe/ffe", mem_addr, mem_addr_12); end
  endtask

  task automatic test_cond();
    logic [2:0] c_tab[3];
    logic [7:0] e_tab[3];
    c_tab[0] = 3'b010; e_tab[0] = 8'h06;
    c_tab[1] = 3'b001; e_tab[1] = 8'h09;
    c_tab[2] = 3'b111; e_tab[2] = 8'h06;
    do_reset(); do_start();
    for (int i = 0; i < 3; i++) begin
      goto_pc(8'h05);
      do_fetch(16'($urandom), $urandom_range(0, 2));
      do_exec(0, 1, 0, 0, c_tab[i], 3'b001, 8'h03, 8'h00, $urandom_range(0, 2));
      checks++; if (mem_addr !== e_tab[i]) begin errors++;
        $display("FAIL cond_%b: got %h expected %h", c_tab[i], mem_addr, e_tab[i]); end
    end
  endtask

  task automatic test_link_halt();
    do_reset(); do_start();
    goto_pc(8'h09);
    do_fetch(16'hC0DE, 0);
    do_exec(0, 0, 1, 1, 3'd0, 3'd0, 8'h00, 8'h40, 1);
    checks++; if (link_pc !== 8'h0A || mem_addr !== 8'h40) begin errors++;
      $display("FAIL link_breg: got link=%h pc=%h expected 0a/40", link_pc, mem_addr); end
    do_fetch(16'hFFFF, 0);
    do_exec(1, 1, 0, 1, 3'b000, 3'd0, 8'h05, 8'h00, 0);
    checks++; if (halted !== 1'b1 || running !== 1'b0 || mem_req !== 1'b0) begin errors++;
      $display("FAIL halt_state: got halted=%b run=%b req=%b expected 1/0/0", halted, running, mem_req); end
    checks++; if (mem_addr !== 8'h41 || link_pc !== 8'h0A) begin errors++;
      $display("FAIL halt_pc: got pc=%h link=%h expected 41/0a", mem_addr, link_pc); end
    start = 1; mem_rdy = 1; repeat (3) tick(); start = 0; mem_rdy = 0;
    checks++; if (halted !== 1'b1 || mem_addr !== 8'h41) begin errors++;
      $display("FAIL halt_sticky: got halted=%b pc=%h expected 1/41", halted, mem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset(); do_start();
    goto_pc(8'h33);
    mem_rdy = 0; tick();
    #2 rst_n = 0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 8'h00 || mem_addr_12 !== 12'h100) begin errors++;
      $display("FAIL reset_mid_fetch: got req=%b pc=%h pc12=%h expected 0/00/100", mem_req, mem_addr, mem_addr_12); end
    tick(); rst_n = 1;
    do_start();
    do_fetch(16'hBEEF, 0);
    exec_done = 1; br_reg = 1; link_en = 1; reg_target = 8'h77;
    #2 rst_n = 0;
    #1;
    checks++; if (ir !== 16'h0000 || mem_addr !== 8'h00 || link_pc !== 8'h00 || running !== 1'b0) begin errors++;
      $display("FAIL reset_mid_exec: got ir=%h pc=%h link=%h run=%b expected 0000/00/00/0", ir, mem_addr, link_pc, running); end
    tick(); clear_inputs(); tick(); rst_n = 1; tick();
    checks++; if (mem_addr !== 8'h00 || running !== 1'b0) begin errors++;
      $display("FAIL reset_release: got pc=%h run=%b expected 00/0", mem_addr, running); end
  endtask

  task automatic test_random();
    int model_pc, model_link, o;
    logic [15:0] data;
    logic be, brr, le;
    logic [2:0] c, st;
    logic [7:0] off, tgt, exp;
    do_reset(); do_start();
    model_pc = 0; model_link = 0;
    exp_q.delete();
    exp_q.push_back(8'h00);
    for (int n = 0; n < 40; n++) begin
      exp = exp_q.pop_front();
      checks++; if (mem_addr !== exp || mem_req !== 1'b1) begin errors++;
        $display("FAIL rand_fetch_addr[%0d]: got %h req=%b expected %h/1", n, mem_addr, mem_req, exp); end
      data = 16'($urandom);
      do_fetch(data, $urandom_range(0, 3));
      model_pc = (model_pc + 1) % 256;
      checks++; if (ir !== data || ir_valid !== 1'b1 || mem_addr !== 8'(model_pc)) begin errors++;
        $display("FAIL rand_ir[%0d]: got ir=%h v=%b pc=%h expected %h/1/%h", n, ir, ir_valid, mem_addr, data, 8'(model_pc)); end
      brr = ($urandom_range(0, 5) == 0);
      be = 1'($urandom); le = 1'($urandom);
      c = 3'($urandom); st = 3'($urandom);
      off = 8'($urandom); tgt = 8'($urandom);
      do_exec(0, be, brr, le, c, st, off, tgt, $urandom_range(0, 3));
      if (le) model_link = model_pc;
      o = (off >= 8'd128) ? int'(off) - 256 : int'(off);
      if (brr) model_pc = int'(tgt);
      else if (be && cond_model(c, st)) model_pc = (model_pc + o + 256) % 256;
      exp_q.push_back(8'(model_pc));
      checks++; if (link_pc !== 8'(model_link)) begin errors++;
        $display("FAIL rand_link[%0d]: got %h expected %h", n, link_pc, 8'(model_link)); end
    end
    exp = exp_q.pop_front();
    checks++; if (mem_addr !== exp) begin errors++; $display("FAIL rand_final_pc: got %h expected %h", mem_addr, exp); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_first_fetch();
    test_wait_states();
    test_wrap();
    test_cond();
    test_link_halt();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a hung sequence.
  initial begin
    #1_000_000;
    $display("FAIL timeout: got no completion expected finish within 1ms");
    $fatal(1);
  end

endmodule
